// File: rtl/mpi_arb_pkg.sv
// Shared types and widths for the packet-granular stream arbiter.
package mpi_arb_pkg;

  localparam int DATA_W    = 64;
  localparam int KEEP_W    = 8;
  localparam int PKT_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // Beat counter must hold MAX_BEATS itself, hence the +1.
  function automatic int beat_cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping modulo N_PORTS.
module rr_pick #(
  parameter  int N_PORTS = 4,
  localparam int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               hit,
  output logic [IDX_W-1:0]   index
);

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      int cand;
      cand = int'(rr_ptr) + i;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      if (req[cand]) begin
        hit   = 1'b1;
        index = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mpi_stream_arbiter.sv
// Packet-granular round-robin arbiter merging N AXI-stream requesters onto one output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick next requester round-robin from rr_ptr
// ST_PASS  | granted port streams straight through to the output
// ST_DRAIN | packet overran MAX_BEATS; swallow beats until its LAST
module mpi_stream_arbiter
  import mpi_arb_pkg::*;
#(
  parameter  int N_PORTS   = 4,
  parameter  int MAX_BEATS = 1024,
  localparam int IDX_W     = $clog2(N_PORTS),
  localparam int BEAT_W    = beat_cnt_w(MAX_BEATS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS*DATA_W-1:0]   s_DATA,
  input  logic [N_PORTS*KEEP_W-1:0]   s_KEEP,
  input  logic [N_PORTS-1:0]          s_LAST,
  input  logic [N_PORTS-1:0]          s_VALID,
  output logic [N_PORTS-1:0]          s_READY,
  output logic [DATA_W-1:0]           m_DATA,
  output logic [KEEP_W-1:0]           m_KEEP,
  output logic                        m_LAST,
  output logic                        m_VALID,
  input  logic                        m_READY,
  output logic                        grant_valid,
  output logic [IDX_W-1:0]            grant_id,
  output logic                        pkt_done,
  output logic                        err_overlen,
  output logic [PKT_CNT_W-1:0]        pkt_count
);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [PKT_CNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic                   pkt_done_q, pkt_done_d;
  logic                   err_q, err_d;

  logic                   pick_hit;
  logic [IDX_W-1:0]       pick_idx;
  logic [DATA_W-1:0]      g_data;
  logic [KEEP_W-1:0]      g_keep;
  logic                   g_last;
  logic                   g_valid;
  logic                   at_limit;
  logic [IDX_W-1:0]       next_ptr;

  rr_pick #(.N_PORTS(N_PORTS)) u_pick (
    .req    (s_VALID),
    .rr_ptr (rr_ptr_q),
    .hit    (pick_hit),
    .index  (pick_idx)
  );

  assign g_data   = s_DATA[grant_id_q*DATA_W +: DATA_W];
  assign g_keep   = s_KEEP[grant_id_q*KEEP_W +: KEEP_W];
  assign g_last   = s_LAST[grant_id_q];
  assign g_valid  = s_VALID[grant_id_q];
  // The beat in flight is beat number MAX_BEATS when MAX_BEATS-1 have already gone.
  assign at_limit = (beat_q == BEAT_W'(MAX_BEATS - 1));
  assign next_ptr = (grant_id_q == IDX_W'(N_PORTS - 1)) ? '0 : grant_id_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    beat_d      = beat_q;
    pkt_count_d = pkt_count_q;
    pkt_done_d  = 1'b0;
    err_d       = 1'b0;
    s_READY     = '0;
    m_DATA      = '0;
    m_KEEP      = '0;
    m_LAST      = 1'b0;
    m_VALID     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_hit) begin
          grant_id_d = pick_idx;
          beat_d     = '0;
          state_d    = ST_PASS;
        end
      end

      ST_PASS: begin
        m_DATA              = g_data;
        m_KEEP              = g_keep;
        m_VALID             = g_valid;
        m_LAST              = g_last | at_limit;
        s_READY[grant_id_q] = m_READY;
        if (g_valid && m_READY) begin
          beat_d = beat_q + BEAT_W'(1);
          if (g_last || at_limit) begin
            pkt_done_d  = 1'b1;
            err_d       = ~g_last;
            pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
            rr_ptr_d    = next_ptr;
            state_d     = g_last ? ST_IDLE : ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        s_READY[grant_id_q] = 1'b1;
        if (g_valid && g_last) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      beat_q      <= '0;
      pkt_count_q <= '0;
      pkt_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      beat_q      <= beat_d;
      pkt_count_q <= pkt_count_d;
      pkt_done_q  <= pkt_done_d;
      err_q       <= err_d;
    end
  end

  assign grant_valid = (state_q != ST_IDLE);
  assign grant_id    = grant_id_q;
  assign pkt_done    = pkt_done_q;
  assign err_overlen = err_q;
  assign pkt_count   = pkt_count_q;

endmodule
